// File: rtl/uart_tx_arbiter_pkg.sv
// Shared configuration for the UART TX arbiter: FSM encoding, default
// end-of-line character and small index helpers.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] LOCK_CHAR_DEF = 8'h0A;
  localparam int         IDLE_CNT_W    = 16;
  localparam int         OWNER_W       = 3;
  localparam int         MAX_REQ       = 8;

  // Next requester index in round-robin order, wrapping n-1 -> 0.
  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                 input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// 'start', wrapping past NUM_REQ-1 back to 0.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] start,
  output logic [OWNER_W-1:0] winner,
  output logic               found
);

  // Padded to the full index range so a 3-bit index is always in bounds.
  logic [MAX_REQ-1:0] req_pad;
  logic [OWNER_W-1:0] idx;

  assign req_pad = MAX_REQ'(req);

  // Walk NUM_REQ slots from start; the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_pad[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = rr_next(idx, NUM_REQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-locked arbiter in front of a UART TX FIFO. A requester keeps the
// grant until it writes LOCK_CHAR or stays idle for TIMEOUT cycles, so
// lines from different requesters never interleave.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] LOCK_CHAR = LOCK_CHAR_DEF,
  parameter int         TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 tx_fifo_full,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner
);

  // Release fires on the idle cycle that brings the counter up to TIMEOUT.
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_M1 = IDLE_CNT_W'(TIMEOUT - 1);

  arb_state_e              state, state_nxt;
  logic [IDLE_CNT_W-1:0]   idle_cnt;
  logic [MAX_REQ-1:0]      valid_pad;
  logic [MAX_REQ-1:0]      ready_pad;
  logic [7:0]              byte_pad [MAX_REQ];
  logic [OWNER_W-1:0]      rr_start;
  logic [OWNER_W-1:0]      rr_win;
  logic                    rr_found;
  logic                    own_valid;
  logic [7:0]              own_byte;
  logic                    xfer;
  logic                    lock_hit;
  logic                    timeout_hit;

  // Pad per-requester lanes to 8 so the owner index never leaves range.
  assign valid_pad = MAX_REQ'(req_valid);
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_lane
    if (i < NUM_REQ) begin : g_on
      assign byte_pad[i] = req_byte[8*i +: 8];
    end else begin : g_off
      assign byte_pad[i] = 8'h00;
    end
  end

  assign own_valid   = valid_pad[owner];
  assign own_byte    = byte_pad[owner];
  assign xfer        = (state == ST_LOCKED) && own_valid && !tx_fifo_full;
  assign lock_hit    = xfer && (own_byte == LOCK_CHAR);
  // Mutually exclusive with xfer: only counts when the owner is not valid.
  assign timeout_hit = (state == ST_LOCKED) && !own_valid && (idle_cnt == TIMEOUT_M1);
  assign busy        = (state == ST_LOCKED);
  assign rr_start    = rr_next(owner, NUM_REQ);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .start  (rr_start),
    .winner (rr_win),
    .found  (rr_found)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the zero-latency handshake/datapath toward the FIFO.
  always_comb begin
    state_nxt = state;
    ready_pad = '0;
    transmit  = 1'b0;
    tx_byte   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (rr_found) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        ready_pad[owner] = !tx_fifo_full;
        transmit         = xfer;
        tx_byte          = own_byte;
        if (lock_hit || timeout_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    req_ready = ready_pad[NUM_REQ-1:0];
  end

  // Grant capture and owner idle counter; a stalled-but-valid owner holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWNER_W'(NUM_REQ - 1);
      idle_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (rr_found) begin
        owner    <= rr_win;
        idle_cnt <= '0;
      end
    end else if (xfer) begin
      idle_cnt <= '0;
    end else if (!own_valid) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (legal range 2..8).
REQ-002 Parameter LOCK_CHAR, default 8'h0A, SHALL be the byte whose transfer ends a grant.
REQ-003 Parameter TIMEOUT, default 255, SHALL be the owner-idle cycle count that forces grant release (legal range 1..65535).
REQ-004 clk  input  1  single clock for all sequential logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  bit i high: requester i offers req_byte slice i.
REQ-007 req_byte  input  NUM_REQ*8  bits [8i+7:8i] are the byte of requester i.
REQ-008 req_ready  output  NUM_REQ  bit i high: requester i's byte is accepted this cycle if valid.
REQ-009 tx_byte  output  8  byte presented to the UART TX FIFO.
REQ-010 transmit  output  1  single-cycle write strobe into the UART TX FIFO.
REQ-011 tx_fifo_full  input  1  UART TX FIFO full; no write may occur while high.
REQ-012 busy  output  1  high while a requester holds the grant.
REQ-013 owner  output  3  index of the current or last grant holder.

Function
REQ-014 A transfer SHALL occur on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-015 The FSM SHALL have two states: IDLE and LOCKED.
REQ-016 In IDLE, when any req_valid is high, the arbiter SHALL register the round-robin winner into owner and enter LOCKED next cycle; no transfer occurs in the grant cycle.
REQ-017 Round-robin search SHALL start at (last owner + 1) mod NUM_REQ and wrap past NUM_REQ-1 to 0.
REQ-018 In LOCKED, req_ready[owner] SHALL equal !tx_fifo_full, and every other req_ready bit SHALL be 0.
REQ-019 In LOCKED, transmit SHALL equal req_valid[owner] && !tx_fifo_full, and tx_byte SHALL equal the owner's req_byte slice (combinational, zero latency).
REQ-020 In IDLE, transmit and all req_ready bits SHALL be 0, and tx_byte SHALL be 8'h00.
REQ-021 A transfer of a byte equal to LOCK_CHAR SHALL return the FSM to IDLE on the next cycle; that byte is still written.
REQ-022 A 16-bit idle counter SHALL clear on grant and on every transfer, increment on each LOCKED cycle with req_valid[owner] low, and hold while req_valid[owner] is high but stalled by tx_fifo_full.
REQ-023 When the idle counter reaches TIMEOUT, the FSM SHALL return to IDLE on the next cycle.
REQ-024 On a simultaneous LOCK_CHAR transfer and timeout, the arbiter SHALL release exactly once.
REQ-025 Requests from non-owners during LOCKED SHALL be held off (ready 0) and never dropped or reordered per requester.
REQ-026 busy SHALL be high exactly in LOCKED.

Reset
REQ-027 Reset SHALL force state IDLE, owner NUM_REQ-1 (so requester 0 wins first), idle counter 0, transmit 0, req_ready 0, busy 0, and tx_byte 8'h00.
REQ-028 Reset asserted mid-line SHALL abandon the grant with no further transmit strobe; the partial line is not resumed.

Structure
REQ-029 The state encodings and the LOCK_CHAR default SHALL live in the shared SoC config include, not locally.
REQ-030 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: request vector and start index; outputs: winner index and found flag).

Verification
REQ-031 Reset release with req_valid=4'b1111 -> grant to 0 after 1 cycle, then 1, 2, 3 in turn as each sends 8'h0A.
REQ-032 Req 2 sends "AB\n" while req 1 is valid throughout -> tx sequence 41,42,0A uninterrupted, then req 1 granted.
REQ-033 Owner sends 8'h41 then drops valid, TIMEOUT=4 -> busy falls 5 cycles after the transfer, and the next requester is granted.
REQ-034 tx_fifo_full held high for 10 cycles with owner valid -> no transmit, no timeout, and the byte is sent on the first cycle full is low.
REQ-035 Reset pulse after 2 bytes of a line -> transmit 0 immediately, owner=NUM_REQ-1, and the next grant goes to the lowest valid index.
REQ-036 A lone 8'h0A from req 3 with timeout expiring the same cycle -> a single write, IDLE next cycle, and no double release.
